fx_accumulator: RTL and testbench

Single-precision floating-point accumulator, wired as a multi-cycle Nios II custom instruction directly downstream of `fx_opt`. Software passes each `f_x` word that `fx_opt` produces into this block, which keeps a running IEEE-754 sum in hardware. Each `f(x)` term then costs one custom-instruction call instead of a software float add. Opcodes clear, accumulate or read the sum.

---
 rtl/fx_accumulator.sv | 154 +++++++++++++++
 tb/tb_fx_accumulator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fx_accumulator.sv
// Single-precision running-sum accumulator used as a multi-cycle custom instruction.
// Opcodes clear, accumulate or read the sum. Results are truncated toward zero and denormals are flushed.
//
// state  | meaning
// IDLE   | waiting for start; clear/read complete directly from here
// UNPACK | unpacked, magnitude-ordered operands held; aligning smaller mantissa
// ALIGN  | aligned mantissas held; adding/subtracting
// ADD    | raw 28-bit sum held; normalising and writing acc
// NORM   | done cycle; acc already updated, start accepted exactly as in IDLE
module fx_accumulator (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM} state_t;

    state_t       r_state;
    logic         r_done;
    logic [31:0]  r_result;
    logic [31:0]  r_acc;
    logic         r_nan;
    logic         r_big_s;
    logic         r_sub;
    logic [7:0]   r_big_e, r_sml_e;
    logic [23:0]  r_big_m, r_sml_m;
    logic [26:0]  r_sml27;
    logic [27:0]  r_sum;

    logic [7:0]   w_a_e, w_b_e;
    logic [23:0]  w_a_m, w_b_m;
    logic         w_a_big;
    logic [7:0]   w_diff;
    logic [26:0]  w_ext, w_shift, w_aligned, w_big27;
    logic         w_lost;
    logic [4:0]   w_lzc;
    logic [25:0]  w_norm;
    logic [22:0]  w_frac;
    logic signed [9:0] w_exp;
    logic [31:0]  w_new_acc;

    assign done   = r_done;
    assign result = r_result;

    // Exponent 0 means zero: denormal fraction bits are discarded.
    assign w_a_e   = dataa[30:23];
    assign w_b_e   = r_acc[30:23];
    assign w_a_m   = (w_a_e == 8'd0) ? 24'd0 : {1'b1, dataa[22:0]};
    assign w_b_m   = (w_b_e == 8'd0) ? 24'd0 : {1'b1, r_acc[22:0]};
    assign w_a_big = {w_a_e, w_a_m} >= {w_b_e, w_b_m};

    assign w_diff    = r_big_e - r_sml_e;
    assign w_ext     = {r_sml_m, 3'b000};
    assign w_shift   = w_ext >> w_diff;
    assign w_lost    = |(w_ext & ((27'd1 << w_diff) - 27'd1));
    assign w_aligned = (w_diff >= 8'd27) ? {26'd0, |r_sml_m}
                                         : {w_shift[26:1], w_shift[0] | w_lost};
    assign w_big27   = {r_big_m, 3'b000};

    always_comb begin
        w_lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i]) w_lzc = 5'(26 - i);
        end
    end

    always_comb begin
        w_norm = r_sum[25:0] << w_lzc;
        if (r_sum[27]) begin
            w_frac = 23'(r_sum >> 4);
            w_exp  = $signed({2'b00, r_big_e}) + 10'sd1;
        end else begin
            w_frac = 23'(w_norm >> 3);
            w_exp  = $signed({2'b00, r_big_e}) - $signed({5'b00000, w_lzc});
        end
        if (r_sum == 28'd0 || w_exp <= 10'sd0)
            w_new_acc = 32'd0;
        else if (w_exp >= 10'sd255)
            w_new_acc = {r_big_s, 8'hFF, 23'd0};
        else
            w_new_acc = {r_big_s, w_exp[7:0], w_frac};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_result <= 32'd0;
            r_acc    <= 32'd0;
            r_nan    <= 1'b0;
            r_big_s  <= 1'b0;
            r_sub    <= 1'b0;
            r_big_e  <= 8'd0;
            r_sml_e  <= 8'd0;
            r_big_m  <= 24'd0;
            r_sml_m  <= 24'd0;
            r_sml27  <= 27'd0;
            r_sum    <= 28'd0;
        end else if (clk_en) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_NORM: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        case (n)
                            2'd0: begin
                                r_acc    <= 32'd0;
                                r_nan    <= 1'b0;
                                r_result <= 32'd0;
                                r_done   <= 1'b1;
                            end
                            2'd1: begin
                                r_nan   <= r_nan | (w_a_e == 8'hFF) | (w_b_e == 8'hFF);
                                r_sub   <= dataa[31] ^ r_acc[31];
                                r_big_s <= w_a_big ? dataa[31] : r_acc[31];
                                r_big_e <= w_a_big ? w_a_e : w_b_e;
                                r_big_m <= w_a_big ? w_a_m : w_b_m;
                                r_sml_e <= w_a_big ? w_b_e : w_a_e;
                                r_sml_m <= w_a_big ? w_b_m : w_a_m;
                                r_state <= S_UNPACK;
                            end
                            default: begin
                                r_result <= r_nan ? QNAN : r_acc;
                                r_done   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_UNPACK: begin
                    r_sml27 <= w_aligned;
                    r_state <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_sum   <= r_sub ? ({1'b0, w_big27} - {1'b0, r_sml27})
                                     : ({1'b0, w_big27} + {1'b0, r_sml27});
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_acc    <= w_new_acc;
                    r_result <= r_nan ? QNAN : w_new_acc;
                    r_done   <= 1'b1;
                    r_state  <= S_NORM;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx_accumulator.sv
// Directed bench for fx_accumulator: hand-computed sums, latencies, reset abort and clock-enable stall.
module tb_fx_accumulator;
    logic        clk = 1'b0;
    logic        reset, clk_en, start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;
    int ndone, lat;
    logic [31:0] res;

    fx_accumulator dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one opcode, count edges until done, check latency and result.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                         input int exp_lat, input logic [31:0] exp_res);
        int cnt;
        cnt = 0;
        @(negedge clk);
        start = 1'b1;
        n     = op;
        dataa = d;
        while (cnt < 12) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cnt++;
            if (done) break;
        end
        chk({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        chk(tag, result, exp_res);
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        n      = 2'd0;
        dataa  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset  = 1'b0;
        clk_en = 1'b1;

        do_op("clr0",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("acc1",   2'd1, 32'h3F80_0000, 4, 32'h3F80_0000);
        do_op("acc2",   2'd1, 32'h4000_0000, 4, 32'h4040_0000);
        do_op("rd3",    2'd2, 32'h0, 1, 32'h4040_0000);
        do_op("rd3op3", 2'd3, 32'h0, 1, 32'h4040_0000);

        do_op("clr1",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("p1",     2'd1, 32'h3F80_0000, 4, 32'h3F80_0000);
        do_op("m1",     2'd1, 32'hBF80_0000, 4, 32'h0000_0000);
        do_op("half",   2'd1, 32'h3F00_0000, 4, 32'h3F00_0000);

        do_op("clr2",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("big",    2'd1, 32'h4B80_0000, 4, 32'h4B80_0000);
        do_op("trunc",  2'd1, 32'h3F80_0000, 4, 32'h4B80_0000);

        do_op("clr3",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("five",   2'd1, 32'h40A0_0000, 4, 32'h40A0_0000);
        do_op("sub3",   2'd1, 32'hC040_0000, 4, 32'h4000_0000);

        do_op("clr4",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("one",    2'd1, 32'h3F80_0000, 4, 32'h3F80_0000);
        do_op("tiny",   2'd1, 32'h3080_0000, 4, 32'h3F80_0000);
        do_op("mtiny",  2'd1, 32'hB080_0000, 4, 32'h3F7F_FFFF);

        do_op("clr5",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("denorm", 2'd1, 32'h0000_0001, 4, 32'h0000_0000);
        do_op("minnrm", 2'd1, 32'h0080_0000, 4, 32'h0080_0000);
        do_op("uflow",  2'd1, 32'h80C0_0000, 4, 32'h0000_0000);

        do_op("clr6",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("max1",   2'd1, 32'h7F7F_FFFF, 4, 32'h7F7F_FFFF);
        do_op("ovf",    2'd1, 32'h7F7F_FFFF, 4, 32'h7F80_0000);
        do_op("inf",    2'd1, 32'h7F80_0000, 4, 32'h7FC0_0000);
        do_op("nanacc", 2'd1, 32'h3F80_0000, 4, 32'h7FC0_0000);
        do_op("nanrd",  2'd2, 32'h0, 1, 32'h7FC0_0000);
        do_op("clr7",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("rdclr",  2'd2, 32'h0, 1, 32'h0000_0000);

        // Reset while the accumulate sits in ALIGN.
        do_op("preacc", 2'd1, 32'h3F80_0000, 4, 32'h3F80_0000);
        @(negedge clk);
        start = 1'b1;
        n     = 2'd1;
        dataa = 32'h4000_0000;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        ndone = 0;
        if (done) ndone++;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("rst_nodone", 32'(ndone), 32'd0);
        do_op("rst_rd", 2'd2, 32'h0, 1, 32'h0000_0000);

        // Stall three cycles in ADD, plus a start issued while busy.
        do_op("clr8",   2'd0, 32'h0, 1, 32'h0000_0000);
        do_op("st1",    2'd1, 32'h3F80_0000, 4, 32'h3F80_0000);
        @(negedge clk);
        start = 1'b1;
        n     = 2'd1;
        dataa = 32'h4000_0000;
        ndone = 0;
        lat   = 0;
        res   = 32'd0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                lat = e;
                res = result;
            end
            case (e)
                1: start = 1'b0;
                2: begin start = 1'b1; n = 2'd1; dataa = 32'h3F80_0000; end
                3: begin start = 1'b0; clk_en = 1'b0; end
                6: clk_en = 1'b1;
                default: ;
            endcase
        end
        chk("stall_ndone", 32'(ndone), 32'd1);
        chk("stall_lat", 32'(lat), 32'd7);
        chk("stall_res", res, 32'h4040_0000);

        // done must hold through disabled cycles.
        @(negedge clk);
        start = 1'b1;
        n     = 2'd2;
        @(posedge clk); #1;
        start  = 1'b0;
        clk_en = 1'b0;
        chk("hold_done0", {31'd0, done}, 32'd1);
        chk("hold_res", result, 32'h4040_0000);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_done2", {31'd0, done}, 32'd1);
        clk_en = 1'b1;
        @(posedge clk); #1;
        chk("hold_drop", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
